// File: rtl/rv_inst_encoder.sv
// rtl/rv_inst_encoder.sv - RV32I field-to-word encoder with address tagging and 2-entry output FIFO
module rv_inst_encoder #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op_code,
  input  logic [3:0]        sub_op_code,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [31:0]       imm,
  input  logic [4:0]        shift_size,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_pulse,
  output logic [1:0]        err_code,
  output logic [7:0]        err_cnt
);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  logic [31:0]       mem_inst [2];
  logic [ADDR_W-1:0] mem_addr [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic [ADDR_W-1:0] addr_cnt;

  logic [2:0]  f3;
  logic [24:0] body;
  logic        bad_op, misaligned, xfer, push, pop;

  assign f3 = sub_op_code[2:0];

  always_comb begin
    body   = '0;
    bad_op = 1'b0;
    case (op_code)
      OP_LUI, OP_AUIPC: body = {imm[31:12], rd};
      OP_OPIMM: begin
        if (f3 == 3'b001 || f3 == 3'b101)
          body = {1'b0, sub_op_code[3], 5'b0, shift_size, rs1, f3, rd};
        else
          body = {imm[11:0], rs1, f3, rd};
      end
      OP_OP:     body = {1'b0, sub_op_code[3], 5'b0, rs2, rs1, f3, rd};
      OP_LOAD:   body = {imm[11:0], rs1, f3, rd};
      OP_STORE:  body = {imm[11:5], rs2, rs1, f3, imm[4:0]};
      OP_BRANCH: body = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11]};
      OP_JAL:    body = {imm[20], imm[10:1], imm[11], imm[19:12], rd};
      OP_JALR:   body = {imm[11:0], rs1, 3'b000, rd};
      default:   bad_op = 1'b1;
    endcase
  end

  // imm[0] never reaches the B/J layouts, so a misaligned word is already the truncated form
  assign misaligned = (op_code == OP_BRANCH || op_code == OP_JAL) && imm[0];

  assign in_ready  = (count != 2'd2) && !clr;
  assign out_valid = (count != 2'd0);
  assign xfer      = in_valid && in_ready;
  assign push      = xfer && !bad_op;
  assign pop       = out_valid && out_ready && !clr;

  // Empty FIFO shows the next address to be assigned, which is BASE_ADDR after reset/clr
  assign out_inst = out_valid ? mem_inst[rd_ptr] : 32'h0;
  assign out_addr = out_valid ? mem_addr[rd_ptr] : addr_cnt;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= {body, op_code, 2'b11};
      mem_addr[wr_ptr] <= addr_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      addr_cnt  <= BASE_ADDR;
      err_pulse <= 1'b0;
      err_code  <= 2'b00;
      err_cnt   <= 8'd0;
    end else if (clr) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      addr_cnt  <= BASE_ADDR;
      err_pulse <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      if (push) begin
        wr_ptr   <= ~wr_ptr;
        addr_cnt <= addr_cnt + ADDR_W'(4);
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count     <= count + {1'b0, push} - {1'b0, pop};
      err_pulse <= xfer && (bad_op || misaligned);
      if (xfer && bad_op)
        err_code <= 2'b01;
      else if (xfer && misaligned)
        err_code <= 2'b10;
      if (xfer && (bad_op || misaligned) && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_rv_inst_encoder.sv
// tb/tb_rv_inst_encoder.sv - directed self-checking bench for rv_inst_encoder
module tb_rv_inst_encoder;

  localparam int ADDR_W = 32;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_ready, out_valid, out_ready, err_pulse;
  logic [4:0]  op_code, rs1, rs2, rd, shift_size;
  logic [3:0]  sub_op_code;
  logic [31:0] imm, out_inst;
  logic [31:0] out_addr;
  logic [1:0]  err_code;
  logic [7:0]  err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  rv_inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_code(op_code), .sub_op_code(sub_op_code),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .shift_size(shift_size),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr),
    .err_pulse(err_pulse), .err_code(err_code), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one field set; caller decides when to drop in_valid
  task automatic drive(input logic [4:0] op, input logic [3:0] sub, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
    in_valid = 1'b1; op_code = op; sub_op_code = sub;
    rd = d; rs1 = s1; rs2 = s2; imm = im; shift_size = 5'd0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_code = '0; sub_op_code = '0; rs1 = '0; rs2 = '0; rd = '0; imm = '0; shift_size = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_addr", out_addr, BASE);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_err_cnt", err_cnt, 0);

    // addi x1,x0,5
    drive(5'b00100, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd5);
    step(); in_valid = 1'b0;
    chk("addi_valid", out_valid, 1);
    chk("addi_inst", out_inst, 32'h00500093);
    chk("addi_addr", out_addr, BASE);
    out_ready = 1'b1; step();
    chk("addi_popped", out_valid, 0);

    // back-to-back stream with out_ready high
    drive(5'b01100, 4'b1000, 5'd3, 5'd1, 5'd2, 32'd0); step();
    chk("sub_inst", out_inst, 32'h402081B3);
    chk("sub_addr", out_addr, BASE + 4);
    drive(5'b01000, 4'b0010, 5'd0, 5'd1, 5'd2, 32'd8); step();
    chk("sw_inst", out_inst, 32'h0020A423);
    chk("sw_addr", out_addr, BASE + 8);
    drive(5'b01101, 4'b0000, 5'd5, 5'd0, 5'd0, 32'h12345000); step();
    chk("lui_inst", out_inst, 32'h123452B7);
    chk("lui_addr", out_addr, BASE + 12);
    chk("lui_valid", out_valid, 1);
    in_valid = 1'b0; step();
    chk("stream_drained", out_valid, 0);

    drive(5'b11000, 4'b0000, 5'd0, 5'd1, 5'd2, 32'd16); step();
    chk("beq_inst", out_inst, 32'h00208863);
    chk("beq_addr", out_addr, BASE + 16);
    drive(5'b11011, 4'b0000, 5'd1, 5'd0, 5'd0, 32'h800); step();
    chk("jal_inst", out_inst, 32'h001000EF);
    chk("jal_no_err", err_pulse, 0);
    drive(5'b11011, 4'b0000, 5'd1, 5'd0, 5'd0, 32'h801); step();
    chk("jalmis_inst", out_inst, 32'h001000EF);
    chk("jalmis_addr", out_addr, BASE + 24);
    chk("jalmis_pulse", err_pulse, 1);
    chk("jalmis_code", err_code, 2'b10);
    chk("jalmis_cnt", err_cnt, 1);
    in_valid = 1'b0; step();
    chk("jalmis_pulse_end", err_pulse, 0);
    chk("jalmis_drained", out_valid, 0);

    // unsupported op_code
    drive(5'b11111, 4'b0000, 5'd1, 5'd1, 5'd1, 32'd0); step(); in_valid = 1'b0;
    chk("bad_no_push", out_valid, 0);
    chk("bad_addr_hold", out_addr, BASE + 28);
    chk("bad_pulse", err_pulse, 1);
    chk("bad_code", err_code, 2'b01);
    chk("bad_cnt", err_cnt, 2);
    step();
    chk("bad_pulse_end", err_pulse, 0);
    drive(5'b11111, 4'b0000, 5'd1, 5'd1, 5'd1, 32'd0);
    repeat (300) step();
    in_valid = 1'b0; step();
    chk("err_cnt_sat", err_cnt, 255);
    chk("sat_no_push", out_valid, 0);

    // clear, then backpressure
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_addr", out_addr, BASE);
    out_ready = 1'b0;
    drive(5'b00100, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd5); step();
    drive(5'b01100, 4'b1000, 5'd3, 5'd1, 5'd2, 32'd0); step();
    chk("full_in_ready", in_ready, 0);
    chk("full_head", out_inst, 32'h00500093);
    drive(5'b01101, 4'b0000, 5'd5, 5'd0, 5'd0, 32'h12345000); step();
    chk("full_head_stable", out_inst, 32'h00500093);
    chk("full_addr_stable", out_addr, BASE);
    in_valid = 1'b0; out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("pop_in_ready", in_ready, 1);
    chk("pop_head", out_inst, 32'h402081B3);
    chk("pop_addr", out_addr, BASE + 4);
    drive(5'b01101, 4'b0000, 5'd5, 5'd0, 5'd0, 32'h12345000); out_ready = 1'b1; step();
    in_valid = 1'b0;
    chk("pp_valid", out_valid, 1);
    chk("pp_head", out_inst, 32'h123452B7);
    chk("pp_addr", out_addr, BASE + 8);
    step();
    chk("pp_drained", out_valid, 0);

    // clr while a transfer is offered both ways
    drive(5'b11111, 4'b0000, 5'd0, 5'd0, 5'd0, 32'd0); step();
    out_ready = 1'b0;
    drive(5'b00100, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd5); step();
    chk("pre_clr_cnt", err_cnt, 1);
    drive(5'b01000, 4'b0010, 5'd0, 5'd1, 5'd2, 32'd8); out_ready = 1'b1; clr = 1'b1;
    #1 chk("clr_in_ready_low", in_ready, 0);
    step(); clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("clr_empty", out_valid, 0);
    chk("clr_addr2", out_addr, BASE);
    chk("clr_cnt2", err_cnt, 0);

    // asynchronous reset mid-stream
    drive(5'b00100, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd5); step();
    drive(5'b11011, 4'b0000, 5'd1, 5'd0, 5'd0, 32'h801); step(); in_valid = 1'b0;
    chk("prerst_valid", out_valid, 1);
    chk("prerst_cnt", err_cnt, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_inst", out_inst, 0);
    chk("arst_addr", out_addr, BASE);
    chk("arst_cnt", err_cnt, 0);
    chk("arst_pulse", err_pulse, 0);
    chk("arst_code", err_code, 0);
    chk("arst_in_ready", in_ready, 1);
    step(); rst = 1'b0; step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
